pipeline_hazard_sequencer: RTL and testbench

//  Owns the D/X/M/W instruction registers of the 5-stage RV32I pipeline and feeds inst_x/inst_m/inst_w to the stage decoders.

---
 rtl/rv_pkg.sv | 55 +++++
 rtl/pipeline_hazard_sequencer_if.sv | 21 ++
 rtl/rv_inst_fields.sv | 33 +++
 rtl/pipeline_hazard_sequencer.sv | 97 +++++++++
 tb/tb_pipeline_hazard_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: opcode classes, NOP,
// forwarding encodings and per-instruction field bundle.
package rv_pkg;

  localparam logic [4:0] itype1 = 5'b00000;
  localparam logic [4:0] itype2 = 5'b00011;
  localparam logic [4:0] itype3 = 5'b00100;
  localparam logic [4:0] itype4 = 5'b11100;
  localparam logic [4:0] itype5 = 5'b11001;
  localparam logic [4:0] rtype1 = 5'b01100;
  localparam logic [4:0] stype  = 5'b01000;
  localparam logic [4:0] sbtype = 5'b11000;
  localparam logic [4:0] utype1 = 5'b01101;
  localparam logic [4:0] utype2 = 5'b00101;
  localparam logic [4:0] ujtype = 5'b11011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b10;

  typedef enum logic [1:0] {
    ACT_ADV,
    ACT_LU,
    ACT_RED,
    ACT_FRZ
  } act_t;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       is_load;
    logic       is_store;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
  } fields_t;

  // M-stage loads are excluded: their data is not ready until W.
  function automatic logic [1:0] fwd_sel(
    input fields_t    m,
    input fields_t    w,
    input logic [4:0] rs,
    input logic       used
  );
    if (used && m.writes_rd && !m.is_load && m.rd == rs)
      return FWD_M;
    if (used && w.writes_rd && w.rd == rs)
      return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_sequencer_if.sv
// Fetch and data-memory handshake seen by the hazard sequencer.
// master = sequencer side, slave = memory side.
interface pipeline_hazard_sequencer_if #(
  parameter int DWIDTH = 32
);
  logic [DWIDTH-1:0] inst_f;
  logic              imem_valid;
  logic              pc_en;
  logic              dmem_req;
  logic              dmem_ready;

  modport master (
    input  inst_f, imem_valid, dmem_ready,
    output pc_en, dmem_req
  );

  modport slave (
    output inst_f, imem_valid, dmem_ready,
    input  pc_en, dmem_req
  );
endinterface

// File: rtl/rv_inst_fields.sv
// Combinational RV32I field extraction and register-usage
// classification for one pipeline stage.
module rv_inst_fields
  import rv_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] inst,
  output fields_t           f
);

  logic [4:0] cls;
  logic       unused_bits;

  assign cls = inst[6:2];
  assign unused_bits =
    ^{inst[DWIDTH-1:25], inst[14:12], inst[1:0]};

  always_comb begin
    f           = '0;
    f.rd        = inst[11:7];
    f.rs1       = inst[19:15];
    f.rs2       = inst[24:20];
    f.is_load   = (cls == itype1);
    f.is_store  = (cls == stype);
    f.uses_rs1  = cls inside {rtype1, itype1, itype3,
                              itype5, stype, sbtype};
    f.uses_rs2  = cls inside {rtype1, stype, sbtype};
    f.writes_rd = !(cls == stype || cls == sbtype)
                  && (inst[11:7] != 5'd0);
  end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// D/X/M/W instruction registers with load-use stall, redirect
// flush, memory-wait freeze, X-stage forwarding and event counters.
module pipeline_hazard_sequencer
  import rv_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_sequencer_if.master bus,
  input  logic                   PCSel,
  output logic [DWIDTH-1:0]      inst_d,
  output logic [DWIDTH-1:0]      inst_x,
  output logic [DWIDTH-1:0]      inst_m,
  output logic [DWIDTH-1:0]      inst_w,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic [CWIDTH-1:0]      stall_cnt,
  output logic [CWIDTH-1:0]      flush_cnt
);

  localparam logic [DWIDTH-1:0] NOP_W = DWIDTH'(NOP);

  fields_t fd, fx, fm, fw;
  act_t    act;
  logic    frz, lu, unused_fields;
  logic [DWIDTH-1:0] d_nxt, x_nxt;

  rv_inst_fields #(.DWIDTH(DWIDTH)) u_fd (.inst(inst_d), .f(fd));
  rv_inst_fields #(.DWIDTH(DWIDTH)) u_fx (.inst(inst_x), .f(fx));
  rv_inst_fields #(.DWIDTH(DWIDTH)) u_fm (.inst(inst_m), .f(fm));
  rv_inst_fields #(.DWIDTH(DWIDTH)) u_fw (.inst(inst_w), .f(fw));

  assign unused_fields = ^{fd, fx, fm, fw};

  assign bus.dmem_req = fm.is_load | fm.is_store;
  assign frz = bus.dmem_req & ~bus.dmem_ready;
  assign lu  = fx.is_load && (fx.rd != 5'd0) &&
               ((fd.uses_rs1 && fd.rs1 == fx.rd) ||
                (fd.uses_rs2 && fd.rs2 == fx.rd));

  assign fwd_a = fwd_sel(fm, fw, fx.rs1, fx.uses_rs1);
  assign fwd_b = fwd_sel(fm, fw, fx.rs2, fx.uses_rs2);

  always_comb begin
    act = ACT_ADV;
    if (frz)        act = ACT_FRZ;
    else if (PCSel) act = ACT_RED;
    else if (lu)    act = ACT_LU;
  end

  always_comb begin
    d_nxt      = bus.imem_valid ? bus.inst_f : NOP_W;
    x_nxt      = inst_d;
    bus.pc_en  = bus.imem_valid;
    unique case (act)
      ACT_FRZ: begin
        d_nxt     = inst_d;
        x_nxt     = inst_x;
        bus.pc_en = 1'b0;
      end
      ACT_RED: begin
        d_nxt     = NOP_W;
        x_nxt     = NOP_W;
        bus.pc_en = 1'b1;
      end
      ACT_LU: begin
        d_nxt     = inst_d;
        x_nxt     = NOP_W;
        bus.pc_en = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_d    <= NOP_W;
      inst_x    <= NOP_W;
      inst_m    <= NOP_W;
      inst_w    <= NOP_W;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (act != ACT_FRZ) begin
      inst_d <= d_nxt;
      inst_x <= x_nxt;
      inst_m <= inst_x;
      inst_w <= inst_m;
      if (act == ACT_LU && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (act == ACT_RED && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for pipeline_hazard_sequencer: reset, load-use,
// forwarding, redirect, freeze, reset mid-stall, counter saturation.
module tb_pipeline_hazard_sequencer;
  localparam int DW = 32;
  localparam int CW = 2;
  localparam logic [31:0] NOPI = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic PCSel = 1'b0;
  logic [DW-1:0] inst_d, inst_x, inst_m, inst_w;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  pipeline_hazard_sequencer_if #(.DWIDTH(DW)) bus ();

  pipeline_hazard_sequencer #(.DWIDTH(DW), .CWIDTH(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .PCSel(PCSel),
    .inst_d(inst_d),
    .inst_x(inst_x),
    .inst_m(inst_m),
    .inst_w(inst_w),
    .fwd_a(fwd_a),
    .fwd_b(fwd_b),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_op(input logic [4:0] rd,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic sub);
    return {1'b0, sub, 5'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] lw_op(input logic [4:0] rd,
    input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] sw_op(input logic [4:0] rs2,
    input logic [4:0] rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction

  function automatic logic [31:0] beq_op(input logic [4:0] rs1,
    input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
  endfunction

  function automatic logic [31:0] addi_op(input logic [4:0] rd,
    input logic [4:0] rs1);
    return {12'd1, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
    input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_nops(input string tag);
    chk({tag, "_d"}, inst_d, NOPI);
    chk({tag, "_x"}, inst_x, NOPI);
    chk({tag, "_m"}, inst_m, NOPI);
    chk({tag, "_w"}, inst_w, NOPI);
  endtask

  logic [31:0] lw5, add6, addi9, add3, sub4, add0, sub00, beq12, sw5;

  initial begin
    lw5   = lw_op(5'd5, 5'd1);
    add6  = r_op(5'd6, 5'd5, 5'd7, 1'b0);
    addi9 = addi_op(5'd9, 5'd0);
    add3  = r_op(5'd3, 5'd1, 5'd2, 1'b0);
    sub4  = r_op(5'd4, 5'd3, 5'd3, 1'b1);
    add0  = r_op(5'd0, 5'd1, 5'd2, 1'b0);
    sub00 = r_op(5'd4, 5'd0, 5'd0, 1'b1);
    beq12 = beq_op(5'd1, 5'd2);
    sw5   = sw_op(5'd5, 5'd1);

    bus.inst_f = $urandom;
    bus.imem_valid = 1'b1;
    bus.dmem_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    bus.inst_f = $urandom;
    tick();
    chk_nops("rst");
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_flush", 32'(flush_cnt), 0);
    chk("rst_fwd_a", 32'(fwd_a), 0);
    chk("rst_fwd_b", 32'(fwd_b), 0);
    chk("rst_pc_en", 32'(bus.pc_en), 1);
    rst_n = 1'b1;

    bus.inst_f = lw5;
    tick();
    bus.inst_f = add6;
    tick();
    #1;
    chk("lu_pc_en", 32'(bus.pc_en), 0);
    bus.inst_f = addi9;
    tick();
    chk("lu_d_hold", inst_d, add6);
    chk("lu_x_nop", inst_x, NOPI);
    chk("lu_m", inst_m, lw5);
    chk("lu_stall", 32'(stall_cnt), 1);
    chk("lu_dmem_req", 32'(bus.dmem_req), 1);
    tick();
    chk("lu_x_add", inst_x, add6);
    chk("lu_w_lw", inst_w, lw5);
    chk("lu_d_next", inst_d, addi9);
    chk("lu_fwd_a", 32'(fwd_a), 2);
    chk("lu_fwd_b", 32'(fwd_b), 0);

    bus.imem_valid = 1'b0;
    #1;
    chk("inv_pc_en", 32'(bus.pc_en), 0);
    repeat (4) tick();
    chk_nops("drain1");
    bus.imem_valid = 1'b1;

    bus.inst_f = add3;
    tick();
    bus.inst_f = sub4;
    tick();
    #1;
    chk("alu_pc_en", 32'(bus.pc_en), 1);
    bus.inst_f = NOPI;
    tick();
    chk("alu_x", inst_x, sub4);
    chk("alu_fwd_a", 32'(fwd_a), 1);
    chk("alu_fwd_b", 32'(fwd_b), 1);
    chk("alu_stall", 32'(stall_cnt), 1);

    bus.inst_f = add3;
    tick();
    bus.inst_f = addi9;
    tick();
    bus.inst_f = sub4;
    tick();
    bus.inst_f = NOPI;
    tick();
    chk("gap_x", inst_x, sub4);
    chk("gap_fwd_a", 32'(fwd_a), 2);
    chk("gap_fwd_b", 32'(fwd_b), 2);

    bus.inst_f = add0;
    tick();
    bus.inst_f = sub00;
    tick();
    bus.inst_f = NOPI;
    tick();
    chk("x0_x", inst_x, sub00);
    chk("x0_m", inst_m, add0);
    chk("x0_fwd_a", 32'(fwd_a), 0);
    chk("x0_fwd_b", 32'(fwd_b), 0);
    repeat (3) tick();

    bus.inst_f = beq12;
    tick();
    bus.inst_f = lw5;
    tick();
    PCSel = 1'b1;
    bus.inst_f = add6;
    #1;
    chk("red_pc_en", 32'(bus.pc_en), 1);
    tick();
    PCSel = 1'b0;
    chk("red_d", inst_d, NOPI);
    chk("red_x", inst_x, NOPI);
    chk("red_m", inst_m, beq12);
    chk("red_flush", 32'(flush_cnt), 1);
    bus.inst_f = NOPI;
    repeat (3) tick();
    chk("red_stall", 32'(stall_cnt), 1);
    chk_nops("drain2");

    bus.inst_f = sw5;
    tick();
    bus.inst_f = addi9;
    tick();
    bus.inst_f = add3;
    tick();
    bus.dmem_ready = 1'b0;
    bus.inst_f = sub4;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) PCSel = 1'b1;
      #1;
      chk("frz_pc_en", 32'(bus.pc_en), 0);
      chk("frz_req", 32'(bus.dmem_req), 1);
      tick();
      chk("frz_d", inst_d, add3);
      chk("frz_x", inst_x, addi9);
      chk("frz_m", inst_m, sw5);
      chk("frz_w", inst_w, NOPI);
      chk("frz_flush", 32'(flush_cnt), 1);
    end
    bus.dmem_ready = 1'b1;
    #1;
    chk("unfrz_pc_en", 32'(bus.pc_en), 1);
    tick();
    PCSel = 1'b0;
    chk("unfrz_d", inst_d, NOPI);
    chk("unfrz_x", inst_x, NOPI);
    chk("unfrz_m", inst_m, addi9);
    chk("unfrz_w", inst_w, sw5);
    chk("unfrz_flush", 32'(flush_cnt), 2);

    bus.inst_f = lw5;
    tick();
    bus.inst_f = add6;
    tick();
    #1;
    chk("rs_pc_en", 32'(bus.pc_en), 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_nops("rs");
    chk("rs_stall", 32'(stall_cnt), 0);
    chk("rs_flush", 32'(flush_cnt), 0);

    for (int i = 0; i < 5; i++) begin
      bus.inst_f = lw5;
      tick();
      bus.inst_f = add6;
      tick();
      bus.inst_f = NOPI;
      tick();
      tick();
      tick();
      chk("sat_stall", 32'(stall_cnt), (i < 3) ? i + 1 : 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
